// File: rtl/game_pkg.sv
// Shared encodings and types for the 2048 game core and the tile renderer.
package game_pkg;

  typedef logic [3:0] tile_t;

  localparam logic [1:0] ST_PLAYING = 2'd0;
  localparam logic [1:0] ST_WON     = 2'd1;
  localparam logic [1:0] ST_LOST    = 2'd2;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam tile_t WIN_TILE_DEFAULT = 4'd11;

  // Board index of element e of line k; element 0 sits on the edge tiles slide toward.
  function automatic logic [3:0] cell_idx(input logic [1:0] dir, input logic [1:0] k,
                                          input logic [1:0] e);
    logic [3:0] idx;
    unique case (dir)
      DIR_LEFT:  idx = {k, e};
      DIR_RIGHT: idx = {k, ~e};
      DIR_UP:    idx = {e, k};
      DIR_DOWN:  idx = {~e, k};
      default:   idx = {k, e};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational slide-and-merge of one 4-tile line toward element 0.
module line_merge
  import game_pkg::*;
(
  input  tile_t [3:0]  tiles_in,
  output tile_t [3:0]  tiles_out,
  output logic         changed,
  output logic [15:0]  score_inc
);

  tile_t       w_packed [5];
  logic [2:0]  w_cnt;
  logic [2:0]  w_out_pos;
  logic        w_skip;
  logic [17:0] w_acc;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_packed[i] = '0;
    end
    w_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (tiles_in[2'(i)] != '0) begin
        w_packed[w_cnt] = tiles_in[2'(i)];
        w_cnt           = w_cnt + 3'd1;
      end
    end

    // w_packed[4] stays zero so the pair test never needs a bounds guard.
    tiles_out = '0;
    w_out_pos = '0;
    w_skip    = 1'b0;
    w_acc     = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_skip) begin
        w_skip = 1'b0;
      end else if (w_packed[3'(i)] != '0) begin
        if (w_packed[3'(i)] == w_packed[3'(i + 1)]) begin
          tiles_out[w_out_pos[1:0]] = (w_packed[3'(i)] == 4'd15) ? 4'd15
                                                                 : w_packed[3'(i)] + 4'd1;
          w_acc  = w_acc + (18'd1 << (w_packed[3'(i)] + 5'd1));
          w_skip = 1'b1;
        end else begin
          tiles_out[w_out_pos[1:0]] = w_packed[3'(i)];
        end
        w_out_pos = w_out_pos + 3'd1;
      end
    end

    changed   = (tiles_out != tiles_in);
    score_inc = (w_acc > 18'h0FFFF) ? 16'hFFFF : w_acc[15:0];
  end

endmodule

// File: rtl/game_core.sv
// 2048 board engine: slides/merges on command, spawns tiles from an LFSR, classifies the game.
module game_core
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter tile_t       WIN_TILE  = WIN_TILE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          move_valid,
  input  logic [1:0]    move_dir,
  output logic          move_ready,
  input  logic          load,
  input  tile_t [15:0]  load_grid,
  output tile_t [15:0]  grid,
  output logic [1:0]    state,
  output logic [15:0]   score
);

  typedef enum logic [2:0] {
    StInit, StIdle, StSlide, StSpawn, StEval, StWon, StLost
  } fsm_e;

  fsm_e         r_fsm, w_fsm_nxt;
  tile_t [15:0] r_grid, w_grid_nxt;
  logic [15:0]  r_score, w_score_nxt;
  logic [1:0]   r_state, w_state_nxt;
  logic [15:0]  r_lfsr;
  logic [1:0]   r_dir, w_dir_nxt;
  logic [1:0]   r_line, w_line_nxt;
  logic         r_changed, w_changed_nxt;
  logic [3:0]   r_spawn_idx, w_spawn_idx_nxt;
  logic         r_spawn_first, w_spawn_first_nxt;
  logic         r_init_more, w_init_more_nxt;

  logic [3:0][3:0] w_cell;
  tile_t [3:0]     w_line_in, w_line_out;
  logic            w_lm_changed;
  logic [15:0]     w_lm_score;
  logic [16:0]     w_score_sum;
  logic [3:0]      w_spawn_pick;
  logic            w_any_win, w_any_empty, w_any_pair;

  always_comb begin
    for (int e = 0; e < 4; e++) begin
      w_cell[2'(e)]    = cell_idx(r_dir, r_line, 2'(e));
      w_line_in[2'(e)] = r_grid[w_cell[2'(e)]];
    end
  end

  line_merge u_line_merge (
    .tiles_in  (w_line_in),
    .tiles_out (w_line_out),
    .changed   (w_lm_changed),
    .score_inc (w_lm_score)
  );

  assign w_score_sum  = {1'b0, r_score} + {1'b0, w_lm_score};
  assign w_spawn_pick = r_spawn_first ? r_lfsr[3:0] : r_spawn_idx;

  always_comb begin
    w_any_win   = 1'b0;
    w_any_empty = 1'b0;
    w_any_pair  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (r_grid[4'(i)] >= WIN_TILE) w_any_win = 1'b1;
      if (r_grid[4'(i)] == '0) w_any_empty = 1'b1;
      if ((i % 4 != 3) && (r_grid[4'(i)] == r_grid[4'(i + 1)])) w_any_pair = 1'b1;
      if ((i < 12) && (r_grid[4'(i)] == r_grid[4'(i + 4)])) w_any_pair = 1'b1;
    end
  end

  always_comb begin
    w_fsm_nxt         = r_fsm;
    w_grid_nxt        = r_grid;
    w_score_nxt       = r_score;
    w_state_nxt       = r_state;
    w_dir_nxt         = r_dir;
    w_line_nxt        = r_line;
    w_changed_nxt     = r_changed;
    w_spawn_idx_nxt   = r_spawn_idx;
    w_spawn_first_nxt = r_spawn_first;
    w_init_more_nxt   = r_init_more;

    unique case (r_fsm)
      StInit: begin
        w_fsm_nxt         = StSpawn;
        w_spawn_first_nxt = 1'b1;
        w_init_more_nxt   = 1'b1;
      end
      StIdle, StWon, StLost: begin
        if (load) begin
          w_grid_nxt    = load_grid;
          w_score_nxt   = '0;
          w_changed_nxt = 1'b0;
          w_fsm_nxt     = StEval;
        end else if (r_fsm == StIdle && move_valid) begin
          w_dir_nxt     = move_dir;
          w_line_nxt    = '0;
          w_changed_nxt = 1'b0;
          w_fsm_nxt     = StSlide;
        end
      end
      StSlide: begin
        for (int e = 0; e < 4; e++) begin
          w_grid_nxt[w_cell[2'(e)]] = w_line_out[2'(e)];
        end
        w_score_nxt   = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        w_changed_nxt = r_changed | w_lm_changed;
        w_line_nxt    = r_line + 2'd1;
        if (r_line == 2'd3) begin
          if (r_changed | w_lm_changed) begin
            w_fsm_nxt         = StSpawn;
            w_spawn_first_nxt = 1'b1;
            w_init_more_nxt   = 1'b0;
          end else begin
            w_fsm_nxt = StEval;
          end
        end
      end
      StSpawn: begin
        w_spawn_first_nxt = 1'b0;
        if (r_grid[w_spawn_pick] == '0) begin
          w_grid_nxt[w_spawn_pick] = (r_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
          if (r_init_more) begin
            w_init_more_nxt   = 1'b0;
            w_spawn_first_nxt = 1'b1;
          end else begin
            w_fsm_nxt = StEval;
          end
        end else begin
          w_spawn_idx_nxt = w_spawn_pick + 4'd1;
        end
      end
      StEval: begin
        if (w_any_win) begin
          w_state_nxt = ST_WON;
          w_fsm_nxt   = StWon;
        end else if (!w_any_empty && !w_any_pair) begin
          w_state_nxt = ST_LOST;
          w_fsm_nxt   = StLost;
        end else begin
          w_state_nxt = ST_PLAYING;
          w_fsm_nxt   = StIdle;
        end
      end
      default: w_fsm_nxt = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm         <= StInit;
      r_grid        <= '0;
      r_score       <= '0;
      r_state       <= ST_PLAYING;
      r_dir         <= '0;
      r_line        <= '0;
      r_changed     <= 1'b0;
      r_spawn_idx   <= '0;
      r_spawn_first <= 1'b0;
      r_init_more   <= 1'b0;
    end else begin
      r_fsm         <= w_fsm_nxt;
      r_grid        <= w_grid_nxt;
      r_score       <= w_score_nxt;
      r_state       <= w_state_nxt;
      r_dir         <= w_dir_nxt;
      r_line        <= w_line_nxt;
      r_changed     <= w_changed_nxt;
      r_spawn_idx   <= w_spawn_idx_nxt;
      r_spawn_first <= w_spawn_first_nxt;
      r_init_more   <= w_init_more_nxt;
    end
  end

  // Fibonacci LFSR, taps 16/14/13/11; free-running so spawn positions depend on timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign move_ready = (r_fsm == StIdle);
  assign grid       = r_grid;
  assign state      = r_state;
  assign score      = r_score;

endmodule

// File: tb/tb_game_core.sv
// Randomised and directed bench for game_core against a list-based 2048 move model.
module tb_game_core;
  import game_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         move_valid = 1'b0;
  logic [1:0]   move_dir = 2'd0;
  logic         load = 1'b0;
  tile_t [15:0] load_grid = '0;
  logic         move_ready;
  tile_t [15:0] grid;
  logic [1:0]   state;
  logic [15:0]  score;

  int n_checks = 0;
  int n_errors = 0;
  int m_board[16];
  int m_next[16];
  int m_gain;
  bit m_changed;
  int exp_score;

  game_core #(.LFSR_SEED(16'hACE1), .WIN_TILE(4'd11)) dut (
    .clk        (clk),
    .rst        (rst),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .load       (load),
    .load_grid  (load_grid),
    .grid       (grid),
    .state      (state),
    .score      (score)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Board position of element e of line k (element 0 = destination edge).
  function automatic int line_pos(input int dir, input int k, input int e);
    case (dir)
      0:       return e * 4 + k;
      1:       return (3 - e) * 4 + k;
      2:       return k * 4 + e;
      default: return k * 4 + (3 - e);
    endcase
  endfunction

  task automatic model_move(input int dir);
    int q[$];
    int o[$];
    int p;
    m_gain    = 0;
    m_changed = 0;
    for (int k = 0; k < 4; k++) begin
      q.delete();
      o.delete();
      for (int e = 0; e < 4; e++) begin
        p = line_pos(dir, k, e);
        if (m_board[p] != 0) q.push_back(m_board[p]);
      end
      while (q.size() > 0) begin
        if (q.size() >= 2 && q[0] == q[1]) begin
          o.push_back((q[0] >= 15) ? 15 : q[0] + 1);
          m_gain += 1 << (q[0] + 1);
          void'(q.pop_front());
          void'(q.pop_front());
        end else begin
          o.push_back(q.pop_front());
        end
      end
      while (o.size() < 4) o.push_back(0);
      for (int e = 0; e < 4; e++) begin
        p = line_pos(dir, k, e);
        m_next[p] = o[e];
        if (o[e] != m_board[p]) m_changed = 1;
      end
    end
  endtask

  function automatic int classify(input int b[16]);
    bit open;
    open = 0;
    for (int i = 0; i < 16; i++) if (b[i] >= 11) return 1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (b[r * 4 + c] == 0) open = 1;
        if (c < 3 && b[r * 4 + c] == b[r * 4 + c + 1]) open = 1;
        if (r < 3 && b[r * 4 + c] == b[(r + 1) * 4 + c]) open = 1;
      end
    end
    return open ? 0 : 2;
  endfunction

  task automatic load_board(input int b[16]);
    @(negedge clk);
    for (int i = 0; i < 16; i++) load_grid[4'(i)] = 4'(b[i]);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) m_board[i] = b[i];
    exp_score = 0;
  endtask

  task automatic do_move(input int dir, output int cycles);
    @(negedge clk);
    check("ready_before_move", int'(move_ready), 1);
    move_valid = 1'b1;
    move_dir   = 2'(dir);
    @(posedge clk);
    #1 move_valid = 1'b0;
    cycles = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (move_ready || state != ST_PLAYING) begin
        cycles = k;
        break;
      end
    end
  endtask

  // Move and verify against the model: one spawned 1/2 tile in a model-empty cell iff changed.
  task automatic move_and_check(input int dir);
    int cycles, diff, obs[16];
    bit spawn_ok;
    model_move(dir);
    do_move(dir, cycles);
    check("move_done", int'(cycles > 0), 1);
    if (m_changed) check("latency_changed", int'(cycles >= 6 && cycles <= 21), 1);
    else check("latency_nochange", cycles, 5);
    diff     = 0;
    spawn_ok = 1;
    for (int i = 0; i < 16; i++) begin
      obs[i] = int'(grid[4'(i)]);
      if (obs[i] != m_next[i]) begin
        diff++;
        if (m_next[i] != 0 || !(obs[i] == 1 || obs[i] == 2)) spawn_ok = 0;
      end
    end
    check("spawn_count", diff, m_changed ? 1 : 0);
    check("spawn_value", int'(spawn_ok), 1);
    exp_score = exp_score + m_gain;
    if (exp_score > 65535) exp_score = 65535;
    check("score", int'(score), exp_score);
    check("state_after_move", int'(state), classify(obs));
    check("ready_after_move", int'(move_ready), int'(classify(obs) == 0));
    for (int i = 0; i < 16; i++) m_board[i] = obs[i];
  endtask

  initial begin
    int b[16];
    int nz, bad, k_ready, dir;

    // Reset
    repeat (3) @(negedge clk);
    nz = 0;
    for (int i = 0; i < 16; i++) if (grid[4'(i)] != 0) nz++;
    check("rst_grid_nonzero", nz, 0);
    check("rst_state", int'(state), 0);
    check("rst_score", int'(score), 0);
    check("rst_ready", int'(move_ready), 0);
    rst = 1'b1;
    k_ready = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (move_ready) begin
        k_ready = k;
        break;
      end
    end
    check("init_ready_in_time", int'(k_ready > 0 && k_ready <= 33), 1);
    nz  = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (grid[4'(i)] != 0) begin
        nz++;
        if (grid[4'(i)] > 2) bad++;
      end
    end
    check("init_tiles", nz, 2);
    check("init_tile_values_bad", bad, 0);
    check("init_state", int'(state), 0);

    // {1,1,2,2} left
    b = '{default: 0};
    b[0] = 1; b[1] = 1; b[2] = 2; b[3] = 2;
    load_board(b);
    move_and_check(2);
    check("pairs_g0", int'(grid[0]), 2);
    check("pairs_g1", int'(grid[1]), 3);
    check("pairs_score", int'(score), 12);

    // {1,1,1,1} left
    b = '{default: 0};
    b[0] = 1; b[1] = 1; b[2] = 1; b[3] = 1;
    load_board(b);
    move_and_check(2);
    check("quad_g0", int'(grid[0]), 2);
    check("quad_g1", int'(grid[1]), 2);
    check("quad_score", int'(score), 8);

    // {1,2,3,4} left: no change
    b = '{default: 0};
    b[0] = 1; b[1] = 2; b[2] = 3; b[3] = 4;
    load_board(b);
    move_and_check(2);
    check("nochange_g3", int'(grid[3]), 4);

    // {10,10} left wins; further moves ignored
    b = '{default: 0};
    b[0] = 10; b[1] = 10;
    load_board(b);
    move_and_check(2);
    check("win_g0", int'(grid[0]), 11);
    check("win_state", int'(state), 1);
    check("win_score", int'(score), 2048);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = 2'd3;
    repeat (10) @(negedge clk);
    move_valid = 1'b0;
    check("won_ignore_g0", int'(grid[0]), 11);
    check("won_ignore_g1", int'(grid[1]), 0);
    check("won_ignore_ready", int'(move_ready), 0);
    check("won_ignore_state", int'(state), 1);

    // Checkerboard is lost; loading zeros recovers
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r * 4 + c] = ((r + c) % 2 == 0) ? 1 : 2;
    load_board(b);
    check("lost_state", int'(state), 2);
    check("lost_ready", int'(move_ready), 0);
    b = '{default: 0};
    load_board(b);
    check("reload_state", int'(state), 0);
    check("reload_score", int'(score), 0);
    check("reload_ready", int'(move_ready), 1);

    // Random boards and sequences of moves
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 16; i++) b[i] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
      load_board(b);
      check("rand_load_state", int'(state), classify(b));
      check("rand_load_score", int'(score), 0);
      for (int m = 0; m < 3; m++) begin
        if (classify(m_board) != 0) break;
        dir = $urandom_range(0, 3);
        move_and_check(dir);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_core.md
# game_core

Upstream producer for the tile renderer: holds the 4×4 board of a 2048-style game and reacts to direction commands by sliding and merging tiles, spawning a new tile, and classifying the game state. It drives the `grid` and `state` buses that the graphics stage draws every frame, plus a running score. A load port lets a bench or debug host force a board.

## Interface

Parameters:
- `LFSR_SEED`, 16'hACE1: nonzero reset value of the spawn LFSR.
- `WIN_TILE`, 4'd11: exponent that wins the game (2^11 = 2048).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `move_valid`  in  1  move request.
- `move_dir`  in  2  0 = up, 1 = down, 2 = left, 3 = right.
- `move_ready`  out  1  move is accepted on a cycle where `move_valid & move_ready`.
- `load`  in  1  one-cycle pulse that forces a board; honoured in IDLE, WON, LOST.
- `load_grid`  in  4×16  board to load, same layout as `grid`.
- `grid`  out  4×16  `grid[r*4+c]`, row 0 at top; 0 = empty, n = tile 2^n.
- `state`  out  2  0 = PLAYING, 1 = WON, 2 = LOST; 3 is never driven.
- `score`  out  16  cumulative merge score, saturating at 16'hFFFF.

## Operation

- Reset values: `grid` all 0, `state` = 0, `score` = 0, `move_ready` = 0, LFSR = `LFSR_SEED`, FSM = INIT.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. Advances every cycle, including while idle.
- FSM states: INIT, IDLE, SLIDE, SPAWN, EVAL, WON, LOST.
- `move_ready` = 1 only in IDLE.
- **INIT**
  - Runs SPAWN twice, then goes to EVAL.
- **SLIDE**
  - Processes one line per cycle, line k = 0..3, through the `line_merge` sub-module.
  - Line mapping:
    - left: row k, cols 0→3
    - right: row k, cols 3→0
    - up: col k, rows 0→3
    - down: col k, rows 3→0
  - Element 0 of each line is the destination edge.
  - `line_merge` compresses non-zero tiles toward element 0.
  - Equal adjacent pairs are merged once each, scanning from element 0. Example: 1,1,1,1 → 2,2,0,0.
  - A merged value is n+1, saturating at 15.
  - `score` += 2^(n+1) per merge, saturating.
  - A sticky `changed` flag is set if any line's output differs from its input.
- **After line 3**
  - `changed` set: go to SPAWN.
  - `changed` clear: go straight to EVAL; no spawn.
- **SPAWN**
  - Candidate index = `lfsr[3:0]` on entry.
  - While the cell is non-empty, index increments mod 16, one cycle per step.
  - On hitting an empty cell, write value 2 if `lfsr[7:4]` == 0, else 1.
  - An empty cell always exists here, so SPAWN takes 1–16 cycles.
- **EVAL** (single cycle, combinational over `grid`)
  - Any cell ≥ `WIN_TILE`: state = WON, FSM = WON.
  - Else, no empty cell and no horizontally or vertically adjacent equal pair: state = LOST, FSM = LOST.
  - Else: state = PLAYING, FSM = IDLE.
- **WON / LOST**
  - Terminal. `move_valid` is ignored.
  - Exit only by `load` or reset.
- **load**
  - `grid` ← `load_grid`, `score` ← 0, `changed` cleared, then EVAL.
  - Ignored in INIT, SLIDE and SPAWN.
  - `load` together with `move_valid` in IDLE: load wins and the move is dropped.
- **Reset mid-operation**: everything clears immediately and the FSM restarts INIT. Partial moves are discarded.

## Timing

- Accepting edge E0 enters SLIDE.
- Lines 0..3 are written at edges E1..E4.
- No change: EVAL at E5, `move_ready` = 1 from E5.
- Change: SPAWN occupies edges E5..E(4+s), s = 1..16; EVAL at E(5+s).
- `grid`, `state` and `score` are registered. Intermediate boards are visible to the renderer during SLIDE, which is acceptable.
- After reset release: INIT completes in ≤ 33 cycles, then `move_ready` = 1.
- After `load`: `state` is updated 2 edges later.

## Structure

- Shared package `game_pkg` holds:
  - state encodings: `ST_PLAYING`, `ST_WON`, `ST_LOST`
  - direction encodings: `DIR_UP`, `DIR_DOWN`, `DIR_LEFT`, `DIR_RIGHT`
  - tile typedef `tile_t` = logic [3:0]
  - `WIN_TILE_DEFAULT`
- The graphics stage imports the same package.
- Sub-module `line_merge` (combinational):
  - inputs: 4 tiles
  - outputs: 4 tiles, `changed`, `score_inc[15:0]`
- FSM, LFSR and EVAL logic stay in `game_core`.

## Test plan

- Reset, then release:
  - During reset: `grid` all 0, `score` = 0, `state` = 0, `move_ready` = 0.
  - Within 33 cycles of release: exactly two non-zero cells, each 1 or 2, and `move_ready` = 1.
- Load row0 = {1,1,2,2}, rest 0; move left:
  - Row0 = {2,3,x,x}, with the two x cells 0 except for at most one spawned tile.
  - Exactly one spawned tile overall; `score` = 12.
- Load row0 = {1,1,1,1}, rest 0; move left:
  - Row0 cols 0–1 = {2,2}; `score` = 8.
- Load row0 = {1,2,3,4}, rest 0; move left:
  - `grid` unchanged, no spawn, `move_ready` high again 5 cycles after acceptance.
- Load row0 = {10,10,0,0}, rest 0; move left:
  - `grid[0]` = 11, `state` = 1, `score` = 2048, `move_ready` stays 0.
  - A further `move_valid` is ignored.
- Load checkerboard `grid[i]` = 1 if (row+col) even, else 2:
  - `state` = 2, `move_ready` = 0.
  - A following `load` of an all-zero board gives `state` = 0, `score` = 0.
